// File: rtl/data_array_port_ctrl.sv
// data_array_port_ctrl: clears a single-port data-array SRAM after reset/flush,
// then round-robins two requesters onto its RW port and returns read data.
module data_array_port_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 256,
  parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  output logic                  init_done,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [MASK_WIDTH-1:0] req0_wmask,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [MASK_WIDTH-1:0] req1_wmask,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  resp0_valid,
  output logic [DATA_WIDTH-1:0] resp0_rdata,
  output logic                  resp1_valid,
  output logic [DATA_WIDTH-1:0] resp1_rdata,
  output logic                  sram_en,
  output logic                  sram_wmode,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [MASK_WIDTH-1:0] sram_wmask,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);
  typedef enum logic {INIT, RUN} state_e;
  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic prio_q, prio_d; // port that wins the next tie
  logic rsp_v_q, rsp_p_q, init_done_q;
  logic run, g1, acc, w;
  logic [ADDR_WIDTH-1:0] a;
  logic [MASK_WIDTH-1:0] m;
  logic [DATA_WIDTH-1:0] d;
  always_comb begin
    run = state_q == RUN;
    g1 = req1_valid & (~req0_valid | prio_q);
    acc = run & ~flush & (req0_valid | req1_valid);
    w = g1 ? req1_write : req0_write;
    a = g1 ? req1_addr : req0_addr;
    m = g1 ? req1_wmask : req0_wmask;
    d = g1 ? req1_wdata : req0_wdata;
    state_d = run ? (flush ? INIT : RUN) : (&cnt_q ? RUN : INIT);
    cnt_d = run ? '0 : cnt_q + 1'b1;
    prio_d = acc ? ~g1 : prio_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q <= '0;
      prio_q <= 1'b0;
      rsp_v_q <= 1'b0;
      rsp_p_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      prio_q <= prio_d;
      rsp_v_q <= acc & ~w;
      rsp_p_q <= g1;
      init_done_q <= state_d == RUN;
    end
  end
  // Every output is forced low while reset is held, independent of state.
  assign init_done = ~reset & init_done_q;
  assign req0_ready = ~reset & acc & ~g1;
  assign req1_ready = ~reset & acc & g1;
  assign sram_en = ~reset & (~run | acc);
  assign sram_wmode = ~reset & (~run | (acc & w));
  assign sram_addr = reset ? '0 : ~run ? cnt_q : acc ? a : '0;
  assign sram_wmask = reset ? '0 : ~run ? '1 : (acc & w) ? m : '0;
  assign sram_wdata = (~reset & acc) ? d : '0;
  assign resp0_valid = ~reset & rsp_v_q & ~rsp_p_q;
  assign resp1_valid = ~reset & rsp_v_q & rsp_p_q;
  assign resp0_rdata = resp0_valid ? sram_rdata : '0;
  assign resp1_rdata = resp1_valid ? sram_rdata : '0;
endmodule

// File: tb/tb_data_array_port_ctrl.sv
// tb_data_array_port_ctrl: directed and random stimulus, checked every cycle
// against a behavioural model of the clear/arbitrate/respond rules.
module tb_data_array_port_ctrl;
  localparam int AW = 9;
  localparam int DW = 256;
  localparam int MW = 32;
  localparam int DEPTH = 512;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic init_done;
  logic req0_valid = 1'b0, req0_ready, req0_write = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [MW-1:0] req0_wmask = '0;
  logic [DW-1:0] req0_wdata = '0;
  logic req1_valid = 1'b0, req1_ready, req1_write = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [MW-1:0] req1_wmask = '0;
  logic [DW-1:0] req1_wdata = '0;
  logic resp0_valid, resp1_valid;
  logic [DW-1:0] resp0_rdata, resp1_rdata;
  logic sram_en, sram_wmode;
  logic [AW-1:0] sram_addr;
  logic [MW-1:0] sram_wmask;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata = '0;
  logic [DW-1:0] sram_mem [DEPTH];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_array_port_ctrl dut (
    .clk(clk), .reset(reset), .flush(flush), .init_done(init_done),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wmask(req0_wmask), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wmask(req1_wmask), .req1_wdata(req1_wdata),
    .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata),
    .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
    .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // SRAM macro: byte-masked write, one-cycle read latency
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_wmode) begin
        for (int b = 0; b < MW; b++)
          if (sram_wmask[b]) sram_mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural model: clearing phase with a running count, then a service
  // phase with a tie preference, a contents array and one pending read.
  logic [DW-1:0] ref_mem [DEPTH];
  logic m_clr = 1'b1;
  logic [9:0] m_cnt = '0;
  logic m_pref = 1'b0;
  logic m_pv = 1'b0, m_pp = 1'b0;
  logic [DW-1:0] m_pdata = '0;
  logic g_v, g_p, e_w, rv0, rv1;
  logic [AW-1:0] e_a;
  logic [MW-1:0] e_m;
  logic [DW-1:0] e_d;
  logic [6:0] x_ctl;
  logic [AW-1:0] x_addr;
  logic [MW-1:0] x_mask;
  logic [DW-1:0] x_wd;

  always @(negedge clk) begin
    g_v = 1'b0;
    g_p = 1'b0;
    if (!reset && !m_clr && !flush && (req0_valid || req1_valid)) begin
      g_v = 1'b1;
      g_p = (req0_valid && req1_valid) ? m_pref : req1_valid;
    end
    e_w = g_p ? req1_write : req0_write;
    e_a = g_p ? req1_addr : req0_addr;
    e_m = g_p ? req1_wmask : req0_wmask;
    e_d = g_p ? req1_wdata : req0_wdata;
    rv0 = !reset && m_pv && !m_pp;
    rv1 = !reset && m_pv && m_pp;
    if (reset) begin
      x_ctl = '0; x_addr = '0; x_mask = '0; x_wd = '0;
    end else if (m_clr) begin
      x_ctl = {1'b0, 1'b0, 1'b0, rv0, rv1, 1'b1, 1'b1};
      x_addr = m_cnt[AW-1:0]; x_mask = '1; x_wd = '0;
    end else begin
      x_ctl = {1'b1, g_v && !g_p, g_v && g_p, rv0, rv1, g_v, g_v && e_w};
      x_addr = g_v ? e_a : '0;
      x_mask = (g_v && e_w) ? e_m : '0;
      x_wd = g_v ? e_d : '0;
    end
    chk("ctl{done,rdy0,rdy1,rv0,rv1,en,wmode}",
        DW'({init_done, req0_ready, req1_ready, resp0_valid, resp1_valid, sram_en, sram_wmode}), DW'(x_ctl));
    chk("sram_addr", DW'(sram_addr), DW'(x_addr));
    chk("sram_wmask", DW'(sram_wmask), DW'(x_mask));
    chk("sram_wdata", sram_wdata, x_wd);
    chk("resp0_rdata", resp0_rdata, rv0 ? m_pdata : '0);
    chk("resp1_rdata", resp1_rdata, rv1 ? m_pdata : '0);
    if (reset) begin
      m_clr = 1'b1; m_cnt = '0; m_pref = 1'b0; m_pv = 1'b0;
    end else begin
      m_pv = 1'b0;
      if (m_clr) begin
        ref_mem[m_cnt[AW-1:0]] = '0;
        m_cnt = m_cnt + 10'd1;
        if (m_cnt == 10'd512) begin m_clr = 1'b0; m_cnt = '0; end
      end else if (flush) begin
        m_clr = 1'b1; m_cnt = '0;
      end
      if (g_v) begin
        m_pref = !g_p;
        if (e_w) begin
          for (int b = 0; b < MW; b++)
            if (e_m[b]) ref_mem[e_a][b*8 +: 8] = e_d[b*8 +: 8];
        end else begin
          m_pv = 1'b1; m_pp = g_p; m_pdata = ref_mem[e_a];
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(input int start, output int n);
    n = start;
    while (!init_done && n < 700) begin
      step();
      n++;
    end
  endtask

  int n, c0, c1;
  logic [DW-1:0] pat;

  initial begin
    for (int i = 0; i < DEPTH; i++) sram_mem[i] = {8{$urandom()}};
    pat = DW'(32'hA5A5A5A5);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    wait_init(1, n);
    chk("init_rise_cycle", DW'(n), DW'(513));
    // write addr 5 low bytes, then read it back
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 9'd5;
    req0_wmask = 32'h0000000F; req0_wdata = {32{8'hA5}};
    step();
    req0_write = 1'b0;
    step();
    req0_valid = 1'b0;
    #1;
    chk("wr_rd_valid", DW'(resp0_valid), DW'(1));
    chk("wr_rd_data", resp0_rdata, pat);
    step();
    // both ports contend; port 0 was served last so port 1 leads
    req0_valid = 1'b1; req0_addr = 9'd5; req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 9'd6;
    c0 = 0; c1 = 0;
    for (int i = 0; i < 7; i++) begin
      if (i == 6) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      #1;
      if (i < 6) chk("tie_grant", DW'({req0_ready, req1_ready}), DW'((i % 2 == 0) ? 2'b01 : 2'b10));
      chk("tie_resp_excl", DW'(resp0_valid & resp1_valid), DW'(0));
      c0 += int'(resp0_valid);
      c1 += int'(resp1_valid);
      step();
    end
    chk("tie_resp0_count", DW'(c0), DW'(3));
    chk("tie_resp1_count", DW'(c1), DW'(3));
    // port 1 streams ten reads
    c1 = 0;
    for (int i = 0; i < 10; i++) begin
      req1_valid = 1'b1; req1_addr = AW'(i);
      #1;
      chk("stream_ready", DW'(req1_ready), DW'(1));
      c1 += int'(resp1_valid);
      step();
    end
    req1_valid = 1'b0;
    #1;
    c1 += int'(resp1_valid);
    chk("stream_resp_count", DW'(c1), DW'(10));
    step();
    // read at T, flush at T+1
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 9'd5;
    #1;
    chk("flush_pre_ready", DW'(req0_ready), DW'(1));
    step();
    flush = 1'b1;
    #1;
    chk("flush_ready", DW'(req0_ready), DW'(0));
    chk("flush_resp_valid", DW'(resp0_valid), DW'(1));
    chk("flush_resp_data", resp0_rdata, pat);
    step();
    flush = 1'b0; req0_valid = 1'b0;
    #1;
    chk("flush_init_drop", DW'(init_done), DW'(0));
    wait_init(2, n);
    chk("flush_resume_cycle", DW'(n), DW'(514));
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 9'd5;
    step();
    req1_valid = 1'b0;
    #1;
    chk("post_flush_valid", DW'(resp1_valid), DW'(1));
    chk("post_flush_data", resp1_rdata, '0);
    step();
    // reset in the middle of a clear
    flush = 1'b1;
    step();
    flush = 1'b0;
    n = 0;
    while (!(sram_en && sram_wmode && sram_addr == 9'd200) && n < 700) begin
      step();
      n++;
    end
    chk("reach_addr_200", DW'(sram_addr), DW'(200));
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("restart_addr", DW'(sram_addr), DW'(0));
    chk("restart_en", DW'(sram_en), DW'(1));
    wait_init(1, n);
    chk("restart_rise_cycle", DW'(n), DW'(513));
    // random traffic
    for (int i = 0; i < 2000; i++) begin
      step();
      req0_valid = $urandom_range(0, 2) != 0;
      req0_write = $urandom_range(0, 1) == 1;
      req0_addr = AW'($urandom_range(0, 15));
      req0_wmask = $urandom();
      req0_wdata = {8{$urandom()}};
      req1_valid = $urandom_range(0, 2) != 0;
      req1_write = $urandom_range(0, 1) == 1;
      req1_addr = AW'($urandom_range(0, 15));
      req1_wmask = $urandom();
      req1_wdata = {8{$urandom()}};
      flush = $urandom_range(0, 399) == 0;
      reset = $urandom_range(0, 999) == 0;
    end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0; flush = 1'b0; reset = 1'b0;
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
